// File: rtl/approx_mul_pipe.sv
// rtl/approx_mul_pipe.sv - 3-stage Baugh-Wooley exact/approximate signed multiplier (optional macro APPROX_MUL_ERRSTAT_EN)
module approx_mul_pipe #(
  parameter int WIDTH      = 16,
  parameter int TRUNC_COLS = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z,
  output logic               out_mode
`ifdef APPROX_MUL_ERRSTAT_EN
  ,
  input  logic               clr_stat,
  output logic [15:0]        err_cnt
`endif
);

  localparam int PW       = 2 * WIDTH;
  // Compensation bit sits below column WIDTH-1, so it never collides with the BW constants.
  localparam int COMP_POS = (TRUNC_COLS > 0) ? TRUNC_COLS - 1 : 0;
  localparam bit COMP_EN  = (TRUNC_COLS > 0);

  // Reduces all Baugh-Wooley partial-product rows plus the constant row to a sum/carry pair.
  function automatic logic [2*PW-1:0] bw_reduce(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic             approx);
    logic [PW-1:0] s;
    logic [PW-1:0] c;
    logic [PW-1:0] row;
    logic [PW-1:0] t;
    logic          pp;
    s = '0;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      row = '0;
      for (int j = 0; j < WIDTH; j++) begin
        pp = a[i] & b[j];
        if ((i == WIDTH - 1) != (j == WIDTH - 1)) pp = ~pp;
        if (approx && (i + j < TRUNC_COLS)) pp = 1'b0;
        row[i+j] = pp;
      end
      t = s ^ c ^ row;
      c = ((s & c) | (s & row) | (c & row)) << 1;
      s = t;
    end
    row = '0;
    row[WIDTH]  = 1'b1;
    row[PW-1]   = 1'b1;
    if (approx && COMP_EN) row[COMP_POS] = 1'b1;
    t = s ^ c ^ row;
    c = ((s & c) | (s & row) | (c & row)) << 1;
    s = t;
    return {s, c};
  endfunction

  logic               r_v1, r_v2, r_v3;
  logic [WIDTH-1:0]   r_x1, r_y1;
  logic               r_mode1, r_mode2, r_mode3;
  logic [PW-1:0]      r_s2, r_c2;
  logic [PW-1:0]      r_z;
  logic [2*PW-1:0]    w_red;
  logic               w_xfer, w_adv2, w_adv1, w_acc;

  // Handshake chain: each stage moves when the one ahead is empty or draining this cycle.
  assign w_xfer   = r_v3 && out_ready;
  assign w_adv2   = r_v2 && (!r_v3 || out_ready);
  assign w_adv1   = r_v1 && (!r_v2 || w_adv2);
  assign in_ready = !r_v1 || w_adv1;
  assign w_acc    = in_valid && in_ready;

  assign out_valid = r_v3;
  assign z         = r_z;
  assign out_mode  = r_mode3;

  // Partial-product reduction for the transaction sitting in S1.
  always_comb begin
    w_red = bw_reduce(r_x1, r_y1, r_mode1);
  end

  // Stage valid flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      if (w_acc)       r_v1 <= 1'b1;
      else if (w_adv1) r_v1 <= 1'b0;
      if (w_adv1)      r_v2 <= 1'b1;
      else if (w_adv2) r_v2 <= 1'b0;
    end
  end

  // S1/S2 datapath: operand capture, then carry-save pair.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_x1    <= x;
      r_y1    <= y;
      r_mode1 <= mode;
    end
    if (w_adv1) begin
      r_s2    <= w_red[2*PW-1:PW];
      r_c2    <= w_red[PW-1:0];
      r_mode2 <= r_mode1;
    end
  end

  // S3: final carry-propagate add; z and out_mode hold while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v3    <= 1'b0;
      r_z     <= '0;
      r_mode3 <= 1'b0;
    end else if (w_adv2) begin
      r_v3    <= 1'b1;
      r_z     <= r_s2 + r_c2;
      r_mode3 <= r_mode2;
    end else if (w_xfer) begin
      r_v3    <= 1'b0;
    end
  end

`ifdef APPROX_MUL_ERRSTAT_EN
  logic [PW-1:0]   r_s2e, r_c2e, r_ex3;
  logic [2*PW-1:0] w_red_ex;
  logic [15:0]     r_err_cnt;

  // Exact shadow reduction travelling alongside every transaction.
  always_comb begin
    w_red_ex = bw_reduce(r_x1, r_y1, 1'b0);
  end

  // Shadow pipeline registers for the exact product.
  always_ff @(posedge clk) begin
    if (w_adv1) begin
      r_s2e <= w_red_ex[2*PW-1:PW];
      r_c2e <= w_red_ex[PW-1:0];
    end
    if (w_adv2) r_ex3 <= r_s2e + r_c2e;
  end

  // Saturating error counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_stat) begin
      r_err_cnt <= '0;
    end else if (w_xfer && r_mode3 && (r_z != r_ex3) && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_approx_mul_pipe.sv
// tb/tb_approx_mul_pipe.sv - scoreboard bench for approx_mul_pipe (checks err_cnt when APPROX_MUL_ERRSTAT_EN is defined)
module tb_approx_mul_pipe;
  localparam int W = 16;
  localparam int T = 6;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, mode, out_valid, out_ready, out_mode;
  logic [W-1:0]  x, y;
  logic [2*W-1:0] z;
`ifdef APPROX_MUL_ERRSTAT_EN
  logic          clr_stat;
  logic [15:0]   err_cnt;
  int            model_err = 0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] z;
    logic        m;
    logic [31:0] ex;
  } exp_t;
  exp_t q[$];

  approx_mul_pipe #(.WIDTH(W), .TRUNC_COLS(T)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .out_mode(out_mode)
`ifdef APPROX_MUL_ERRSTAT_EN
    , .clr_stat(clr_stat), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference: true signed product, minus the low-column bits dropped, plus the rounding constant.
  function automatic logic [31:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    longint p;
    p = $signed(a) * $signed(b);
    if (m) begin
      for (int i = 0; i < W; i++)
        for (int j = 0; j < W; j++)
          if (i + j < T) p = p - (longint'(a[i] & b[j]) << (i + j));
      if (T > 0) p = p + (longint'(1) << (T - 1));
    end
    return p[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic m, input logic ordy, output logic acc);
    exp_t e;
    int   inflight;
    @(negedge clk);
    out_ready = ordy;
    in_valid  = v;
    x = a; y = b; mode = m;
    #1;
    acc = v && in_ready;
    if (acc) begin
      inflight = q.size() - ((out_valid && out_ready) ? 1 : 0);
      chk("inflight_le3", 64'(inflight <= 3), 64'd1);
      e.z = ref_prod(a, b, m);
      e.m = m;
      e.ex = ref_prod(a, b, 1'b0);
      q.push_back(e);
    end
  endtask

  // Monitor: pops on each output transfer and checks hold behaviour under stall.
  initial begin
    logic        prev_stall;
    logic [31:0] prev_z;
    logic        prev_mode;
    exp_t        e;
    prev_stall = 1'b0;
    prev_z = '0;
    prev_mode = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && out_valid) begin
          chk("hold_z", 64'(z), 64'(prev_z));
          chk("hold_mode", 64'(out_mode), 64'(prev_mode));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got z=%0h expected no output", z);
          end else begin
            e = q.pop_front();
            chk("z", 64'(z), 64'(e.z));
            chk("out_mode", 64'(out_mode), 64'(e.m));
`ifdef APPROX_MUL_ERRSTAT_EN
            if (e.m && (e.z != e.ex) && (model_err < 65535)) model_err++;
`endif
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_z = z;
        prev_mode = out_mode;
      end
    end
  end

  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    logic acc;
    int   n;
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) drive(1'b1, a, b, m, 1'b1, acc);
    chk("directed_accept", 64'(acc), 64'd1);
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1, acc);
      if (out_valid) begin
        n = k;
        break;
      end
    end
    chk("latency", 64'(n), 64'd3);
  endtask

  task automatic drain(input string name);
    logic acc;
    for (int k = 0; k < 60 && q.size() != 0; k++) drive(1'b0, '0, '0, 1'b0, 1'b1, acc);
    for (int k = 0; k < 3; k++) drive(1'b0, '0, '0, 1'b0, 1'b1, acc);
    chk(name, 64'(q.size()), 64'd0);
  endtask

  initial begin
    logic          acc;
    logic [W-1:0]  a, b;
    logic          m;
    int            n, stalls, cyc;
    logic [3:0]    pat;
    pat = 4'b1001;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0; mode = 1'b0;
`ifdef APPROX_MUL_ERRSTAT_EN
    clr_stat = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_z", 64'(z), 64'd0);
    chk("reset_out_mode", 64'(out_mode), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    directed(16'h8000, 16'h8000, 1'b0);
    directed(16'h0001, 16'h0001, 1'b1);
    directed(16'h8000, 16'h8000, 1'b1);
    directed(16'hFFFF, 16'h0003, 1'b0);
    chk("ref_035", 64'(ref_prod(16'h8000, 16'h8000, 1'b0)), 64'h40000000);
    chk("ref_036", 64'(ref_prod(16'h0001, 16'h0001, 1'b1)), 64'h00000020);
`ifdef APPROX_MUL_ERRSTAT_EN
    drain("drain_directed");
    chk("err_cnt_directed", 64'(err_cnt), 64'(model_err));
`endif

    stalls = 0;
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b1, acc);
      if (!acc) stalls++;
    end
    chk("throughput_stalls", 64'(stalls), 64'd0);
    drain("drain_throughput");

    n = 0; cyc = 0;
    a = W'($urandom); b = W'($urandom); m = 1'($urandom);
    while (n < 10 && cyc < 200) begin
      drive(1'b1, a, b, m, pat[3 - (cyc % 4)], acc);
      cyc++;
      if (acc) begin
        n++;
        a = W'($urandom); b = W'($urandom); m = 1'($urandom);
      end
    end
    chk("backpressure_accepted", 64'(n), 64'd10);
    drain("drain_backpressure");

    n = 0;
    for (int k = 0; k < 10 && n < 3; k++) begin
      drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0, acc);
      if (acc) n++;
    end
    chk("midreset_inflight", 64'(n), 64'd3);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    q.delete();
`ifdef APPROX_MUL_ERRSTAT_EN
    model_err = 0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    for (int k = 0; k < 8; k++) drive(1'b0, '0, '0, 1'b0, 1'b1, acc);

    for (int k = 0; k < 40; k++)
      drive(1'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), acc);
    drain("drain_random");

`ifdef APPROX_MUL_ERRSTAT_EN
    chk("err_cnt_final", 64'(err_cnt), 64'(model_err));
    @(negedge clk);
    clr_stat = 1'b1;
    @(negedge clk);
    clr_stat = 1'b0;
    #1;
    chk("err_cnt_clear", 64'(err_cnt), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/approx_mul_pipe.md
APPROX_MUL_PIPE -- requirements
Module: approx_mul_pipe

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits, two's-complement; legal range 4..32.
REQ-002 Parameter TRUNC_COLS, default 6: number of low partial-product columns dropped in approximate mode; legal range 0..WIDTH-1.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 Port in_valid, input, 1: operands and mode are valid this cycle.
REQ-006 Port in_ready, output, 1: block accepts a transaction this cycle.
REQ-007 Port x, input, WIDTH: signed multiplicand.
REQ-008 Port y, input, WIDTH: signed multiplier.
REQ-009 Port mode, input, 1: selects the product type; 0 = exact, 1 = approximate.
REQ-010 Port out_valid, output, 1: z is valid.
REQ-011 Port out_ready, input, 1: downstream accepts z this cycle.
REQ-012 Port z, output, 2*WIDTH: signed product.
REQ-013 Port out_mode, output, 1: mode of the transaction currently on z.

Function
REQ-014 Input acceptance SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-015 Products SHALL use Baugh-Wooley partial products, with these bit values:
- pp[i][j] = x[i]&y[j] when neither index is WIDTH-1, or when both are;
- the complement of x[i]&y[j] otherwise;
- constant 1s added at columns WIDTH and 2*WIDTH-1.
REQ-016 Exact mode SHALL give z = x*y modulo 2^(2*WIDTH), with no error.
REQ-017 Approximate mode SHALL drop every pp[i][j] with i+j < TRUNC_COLS.
REQ-018 When TRUNC_COLS > 0, approximate mode SHALL add the compensation constant 2^(TRUNC_COLS-1).
REQ-019 With TRUNC_COLS = 0, approximate mode SHALL equal exact mode.
REQ-020 The pipeline SHALL have three stages:
- S1 registers x, y and mode;
- S2 reduces the partial products to a carry-save sum/carry pair;
- S3 performs the final carry-propagate add into z.
REQ-021 Latency SHALL be 3 cycles from acceptance to out_valid with no backpressure; throughput SHALL be 1 transaction per cycle.
REQ-022 Each stage SHALL load when it is empty or when its contents advance in the same cycle (bubble-collapsing).
REQ-023 in_ready SHALL equal !S1_full || S1 advances, and SHALL be combinational from out_ready.
REQ-024 While out_valid && !out_ready:
- z and out_mode SHALL hold stable;
- no transaction SHALL be lost or duplicated;
- at most 3 transactions SHALL be in flight.
REQ-025 Transactions SHALL exit in acceptance order, each carrying its own mode; mode MAY change every cycle.
REQ-026 Simultaneous accept and output transfer on a full pipe SHALL sustain 1 transaction per cycle.

Reset
REQ-027 When rst_n = 0 at a clock edge, all stage valid flags SHALL clear; the following outputs SHALL then read:
- out_valid = 0;
- z = 0;
- out_mode = 0;
- in_ready = 1.
REQ-028 Reset mid-operation SHALL discard all in-flight transactions; none SHALL emerge after reset release.
REQ-029 Datapath registers other than z MAY be left unreset.

Configuration
REQ-030 Macro APPROX_MUL_ERRSTAT_EN SHALL control the error-statistics feature.
REQ-031 When APPROX_MUL_ERRSTAT_EN is defined, the block SHALL add:
- an input clr_stat, 1 bit;
- an output err_cnt, 16 bits;
- an exact product computed alongside every approximate-mode transaction.
REQ-032 With the macro defined, err_cnt SHALL increment, saturating at 0xFFFF, on each output transfer where out_mode = 1 and z differs from the exact product.
REQ-033 With the macro defined, clr_stat or reset SHALL zero err_cnt; clr_stat SHALL take priority over a same-cycle increment.
REQ-034 When APPROX_MUL_ERRSTAT_EN is undefined, clr_stat, err_cnt and the exact shadow logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (WIDTH=16, TRUNC_COLS=6)
REQ-035 Exact corner: x=0x8000, y=0x8000, mode=0 -> z=0x40000000 three cycles after acceptance.
REQ-036 Approximate compensation: x=1, y=1, mode=1 -> z=0x00000020; with the macro defined, err_cnt increments to 1.
REQ-037 Approximate high columns: x=0x8000, y=0x8000, mode=1 -> z=0x40000020.
REQ-038 Exact negative: x=0xFFFF, y=0x0003, mode=0 -> z=0xFFFFFFFD.
REQ-039 Backpressure: feed 10 back-to-back random transactions with out_ready toggling 1,0,0,1:
- z SHALL hold stable while stalled;
- results SHALL exit in order;
- each result SHALL match the REQ-015..REQ-018 model.
REQ-040 Reset mid-stream: assert rst_n=0 for 1 cycle with 3 transactions in flight -> out_valid=0 the next cycle and no stale outputs afterwards.
